// File: rtl/store_narrow_buffer.sv
// Store narrowing stage: lane-aligns byte/half/word stores and queues them for data memory.
// Optional build macro STORE_MERGE_EN folds same-word stores into the tail entry.
module store_narrow_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             st_valid_i,
    output logic             st_ready_o,
    input  logic [31:0]      st_addr_i,
    input  logic [31:0]      st_data_i,
    input  logic [1:0]       st_size_i,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_o,
    output logic [3:0]       mem_be_o,
    output logic             misalign_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             misalign_q, misalign_d;

    logic [1:0]       k;
    logic             legal;
    logic [31:0]      lane_data;
    logic [3:0]       lane_be;
    logic [31:0]      lane_mask;

    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic             merge;

    assign k      = st_addr_i[1:0];
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);

    // Ready depends only on occupancy; a pop this cycle never frees a slot early.
    assign st_ready_o  = rst_i && !full;
    assign mem_valid_o = !empty;
    assign empty_o     = empty;
    assign count_o     = count_q;
    assign misalign_o  = misalign_q;

    assign accept = st_valid_i && st_ready_o;
    assign pop    = mem_valid_o && mem_ready_i;

    assign mem_addr_o = {addr_q[rd_ptr_q], 2'b00};
    assign mem_data_o = data_q[rd_ptr_q];
    assign mem_be_o   = be_q[rd_ptr_q];

    // Truncate the operand to the access size and steer it onto its byte lanes.
    always_comb begin
        legal     = 1'b0;
        lane_data = '0;
        lane_be   = '0;
        unique case (st_size_i)
            2'b00: begin
                legal     = 1'b1;
                lane_be   = 4'b0001 << k;
                lane_data = 32'(st_data_i[7:0]) << {k, 3'b000};
            end
            2'b01: begin
                legal     = !k[0];
                lane_be   = 4'b0011 << {k[1], 1'b0};
                lane_data = 32'(st_data_i[15:0]) << {k[1], 4'b0000};
            end
            2'b10: begin
                legal     = (k == 2'b00);
                lane_be   = 4'b1111;
                lane_data = st_data_i;
            end
            default: begin
                legal     = 1'b0;
            end
        endcase
    end

    assign lane_mask = {{8{lane_be[3]}}, {8{lane_be[2]}},
                        {8{lane_be[1]}}, {8{lane_be[0]}}};

`ifdef STORE_MERGE_EN
    logic [PW-1:0] tail_ptr;

    assign tail_ptr = wr_ptr_q - PW'(1);
    // The tail is only off limits when it is also the head leaving this cycle.
    assign merge = accept && legal && !empty
                && (addr_q[tail_ptr] == st_addr_i[31:2])
                && !(pop && count_q == CNT_W'(1));
`else
    assign merge = 1'b0;
`endif

    assign push = accept && legal && !merge;

    // Pointer, occupancy and reject-pulse next state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        misalign_d = accept && !legal;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Entry storage; cleared on reset so the head outputs read as zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else if (push) begin
            addr_q[wr_ptr_q] <= st_addr_i[31:2];
            data_q[wr_ptr_q] <= lane_data;
            be_q[wr_ptr_q]   <= lane_be;
        end
`ifdef STORE_MERGE_EN
        else if (merge) begin
            data_q[tail_ptr] <= (data_q[tail_ptr] & ~lane_mask)
                              | (lane_data & lane_mask);
            be_q[tail_ptr]   <= be_q[tail_ptr] | lane_be;
        end
`endif
    end

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Directed bench for store_narrow_buffer with a scoreboard-driven drain monitor.
// Expected entries are hand-computed and queued at acceptance time.
module tb_store_narrow_buffer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        st_valid_i;
    logic        st_ready_o;
    logic [31:0] st_addr_i;
    logic [31:0] st_data_i;
    logic [1:0]  st_size_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_be_o;
    logic        misalign_o;
    logic        empty_o;
    logic [2:0]  count_o;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    store_narrow_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .st_valid_i  (st_valid_i),
        .st_ready_o  (st_ready_o),
        .st_addr_i   (st_addr_i),
        .st_data_i   (st_data_i),
        .st_size_i   (st_size_i),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_be_o    (mem_be_o),
        .misalign_o  (misalign_o),
        .empty_o     (empty_o),
        .count_o     (count_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every negedge with a pending handshake pops one expected entry.
    always @(negedge clk) begin
        if (rst_i && mem_valid_o && mem_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_entry", mem_addr_o, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mem_addr", mem_addr_o, e.addr);
                chk("mem_data", mem_data_o, e.data);
                chk("mem_be", 32'(mem_be_o), 32'(e.be));
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input bit exp_push,
                         input logic [31:0] ea, input logic [31:0] ed,
                         input logic [3:0] ebe);
        int n;
        st_valid_i = 1'b1;
        st_addr_i  = a;
        st_data_i  = d;
        st_size_i  = sz;
        n = 0;
        @(negedge clk);
        while (!st_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!st_ready_o) chk("accept_timeout", 32'(st_ready_o), 32'd1);
        @(posedge clk);
        if (exp_push) sb.push_back('{addr: ea, data: ed, be: ebe});
        #1 st_valid_i = 1'b0;
    endtask

    task automatic reject(input logic [31:0] a, input logic [1:0] sz);
        store(a, 32'h0BAD_F00D, sz, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("misalign_pulse", 32'(misalign_o), 32'd1);
        @(negedge clk);
        chk("misalign_end", 32'(misalign_o), 32'd0);
        chk("reject_count", 32'(count_o), 32'd0);
        chk("reject_valid", 32'(mem_valid_o), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(empty_o), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i       = 1'b0;
        st_valid_i  = 1'b0;
        st_addr_i   = '0;
        st_data_i   = '0;
        st_size_i   = '0;
        mem_ready_i = 1'b0;
        #2;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_valid", 32'(mem_valid_o), 32'd0);
        chk("rst_ready", 32'(st_ready_o), 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_data", mem_data_o, 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        #10 rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(st_ready_o), 32'd1);

        // Lane placement with memory always ready.
        mem_ready_i = 1'b1;
        store(32'h1003, 32'h0000_00A5, 2'b00, 1'b1,
              32'h1000, 32'hA500_0000, 4'b1000);
        @(negedge clk);
        chk("latency", 32'(mem_valid_o), 32'd1);
        @(posedge clk);
        #1;
        store(32'h2002, 32'h1234_BEEF, 2'b01, 1'b1,
              32'h2000, 32'hBEEF_0000, 4'b1100);
        store(32'h4001, 32'hFFFF_FF77, 2'b00, 1'b1,
              32'h4000, 32'h0000_7700, 4'b0010);
        store(32'h4000, 32'h9999_CAFE, 2'b01, 1'b1,
              32'h4000, 32'h0000_CAFE, 4'b0011);
        store(32'h5000, 32'hDEAD_BEEF, 2'b10, 1'b1,
              32'h5000, 32'hDEAD_BEEF, 4'b1111);
        drain();

        // Rejected requests.
        reject(32'h2001, 2'b01);
        reject(32'h3002, 2'b10);
        reject(32'h3000, 2'b11);

        // Fill under backpressure, then drain in order.
        mem_ready_i = 1'b0;
        store(32'h100, 32'h1111_1111, 2'b10, 1'b1, 32'h100, 32'h1111_1111, 4'hF);
        store(32'h104, 32'h2222_2222, 2'b10, 1'b1, 32'h104, 32'h2222_2222, 4'hF);
        store(32'h108, 32'h3333_3333, 2'b10, 1'b1, 32'h108, 32'h3333_3333, 4'hF);
        store(32'h10C, 32'h4444_4444, 2'b10, 1'b1, 32'h10C, 32'h4444_4444, 4'hF);
        st_valid_i = 1'b1;
        st_addr_i  = 32'h150;
        st_data_i  = 32'h5555_5555;
        st_size_i  = 2'b10;
        @(negedge clk);
        chk("full_ready", 32'(st_ready_o), 32'd0);
        chk("full_count", 32'(count_o), 32'd4);
        @(posedge clk);
        #1 mem_ready_i = 1'b1;
        @(negedge clk);
        chk("no_bypass", 32'(st_ready_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_pop", 32'(st_ready_o), 32'd1);
        chk("count_after_pop", 32'(count_o), 32'd3);
        @(posedge clk);
        sb.push_back('{addr: 32'h150, data: 32'h5555_5555, be: 4'hF});
        #1 st_valid_i = 1'b0;
        drain();

        // Asynchronous reset while entries are queued.
        mem_ready_i = 1'b0;
        store(32'h200, 32'hAAAA_0001, 2'b10, 1'b1, 32'h200, 32'hAAAA_0001, 4'hF);
        store(32'h204, 32'hAAAA_0002, 2'b10, 1'b1, 32'h204, 32'hAAAA_0002, 4'hF);
        store(32'h208, 32'hAAAA_0003, 2'b10, 1'b1, 32'h208, 32'hAAAA_0003, 4'hF);
        #2 rst_i = 1'b0;
        #1;
        chk("midrst_valid", 32'(mem_valid_o), 32'd0);
        chk("midrst_count", 32'(count_o), 32'd0);
        sb.delete();
        #2 rst_i = 1'b1;
        @(posedge clk);
        #1 mem_ready_i = 1'b1;
        store(32'h600, 32'h0600_0600, 2'b10, 1'b1, 32'h600, 32'h0600_0600, 4'hF);
        @(negedge clk);
        chk("post_rst_latency", 32'(mem_valid_o), 32'd1);
        drain();

        // Two bytes to the same word while memory stalls.
        mem_ready_i = 1'b0;
`ifdef STORE_MERGE_EN
        store(32'h40, 32'h0000_0011, 2'b00, 1'b0, 32'h0, 32'h0, 4'h0);
        store(32'h41, 32'h0000_0022, 2'b00, 1'b0, 32'h0, 32'h0, 4'h0);
        sb.push_back('{addr: 32'h40, data: 32'h0000_2211, be: 4'b0011});
        @(negedge clk);
        chk("merge_count", 32'(count_o), 32'd1);
        chk("merge_data", mem_data_o, 32'h0000_2211);
        chk("merge_be", 32'(mem_be_o), 32'd3);
`else
        store(32'h40, 32'h0000_0011, 2'b00, 1'b1, 32'h40, 32'h0000_0011, 4'b0001);
        store(32'h41, 32'h0000_0022, 2'b00, 1'b1, 32'h40, 32'h0000_2200, 4'b0010);
        @(negedge clk);
        chk("nomerge_count", 32'(count_o), 32'd2);
`endif
        @(posedge clk);
        #1 mem_ready_i = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/store_narrow_buffer.md
# store_narrow_buffer

Store-side narrowing and buffering stage between the EX/MEM pipeline register and data memory. It takes a 32-bit register operand plus an access size, truncates it to byte, halfword or word, places it in the correct little-endian byte lanes with byte enables, and queues it in a small FIFO. The FIFO drains to data memory over a valid/ready handshake. It is the write-direction counterpart of the load and immediate sign-extension path.

## Interface
- DEPTH, 4: number of FIFO entries; power of two, 2..16.
- CNT_W, 3: width of `count_o`; must hold 0..DEPTH.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous active-low reset.
- st_valid_i  in  1  store request valid.
- st_ready_o  out  1  buffer can accept a store this cycle.
- st_addr_i  in  32  byte address of the store.
- st_data_i  in  32  register operand; only the low 8/16/32 bits are used.
- st_size_i  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- mem_valid_o  out  1  head entry is valid.
- mem_ready_i  in  1  memory accepts the head entry.
- mem_addr_o  out  32  word-aligned address, with [1:0] = 00.
- mem_data_o  out  32  lane-aligned write data.
- mem_be_o  out  4  byte enables; bit k enables lane [8k+7:8k].
- misalign_o  out  1  one-cycle pulse when a request is rejected as misaligned or illegal.
- empty_o  out  1  FIFO empty, for fence/drain logic.
- count_o  out  CNT_W  current occupancy.

## Operation
- Accept: the request is accepted when `st_valid_i && st_ready_o`. `st_ready_o = !full`. It is forced to 0 while `rst_i` is low.
- Narrowing, with k = addr[1:0]:
  - Byte: data[7:0] is placed at lane k, be = 1<<k.
  - Half: requires addr[0] = 0. data[15:0] is placed at lanes {2h+1, 2h} where h = addr[1], be = 4'b0011<<(2h).
  - Word: requires addr[1:0] = 00. Data passes through, be = 4'b1111.
  - Lanes that are not enabled are driven as 0.
- Rejection: a misaligned halfword, a misaligned word, or size 11 is accepted (it consumes the handshake) but is not enqueued. `misalign_o` pulses high on the next cycle. No state other than `misalign_o` changes.
- FIFO:
  - Push writes the tail entry {addr[31:2], data, be}.
  - Pop occurs when `mem_valid_o && mem_ready_i`.
  - Push and pop in the same cycle leave `count_o` unchanged.
- Outputs: `mem_valid_o = !empty`. `mem_addr_o`, `mem_data_o` and `mem_be_o` come directly from head-entry registers and are stable while `mem_valid_o && !mem_ready_i`.
- Pointers: read and write pointers wrap modulo DEPTH. Full and empty are derived from `count_o`.
- Reset (async, `rst_i` = 0): `count_o` = 0, `empty_o` = 1, `mem_valid_o` = 0, `mem_addr_o`/`mem_data_o`/`mem_be_o` = 0, `misalign_o` = 0, pointers = 0. Reset mid-drain discards all queued entries.

## Timing
- Latency: a store accepted in cycle N into an empty FIFO appears on `mem_valid_o` in cycle N+1.
- Throughput: one push and one pop per cycle.
- When full, `st_ready_o` = 0 in the same cycle. It is not raised by a pop in that same cycle; there is no bypass. It re-asserts the cycle after a pop.
- `misalign_o` is registered and lasts exactly one cycle per rejected request.
- The only combinational paths are `full` → `st_ready_o` and `empty` → `mem_valid_o`. There is no path from `mem_ready_i` to `st_ready_o`.

## Configuration
- STORE_MERGE_EN defined:
  - A legal store whose word address equals the tail entry's address merges into that entry instead of pushing, provided the entry is not being popped this cycle. When `count_o` = 1 and a pop occurs, there is no merge and a normal push happens.
  - Merge rule: new enabled lanes overwrite the entry's data and `be |= new_be`. `count_o` is unchanged.
  - Merge takes effect only when `st_ready_o` = 1, so the full rule is unchanged.
- STORE_MERGE_EN undefined: every legal store occupies its own entry; no merge logic is compiled in.

## Test plan
- Byte lanes: store byte 0x...A5 to 0x1003, with `mem_ready_i` = 1 → next cycle `mem_addr_o` = 0x1000, `mem_data_o` = 0xA5000000, `mem_be_o` = 4'b1000.
- Halfword: store half 0x1234BEEF to 0x2002 → `mem_data_o` = 0xBEEF0000, `mem_be_o` = 4'b1100.
- Misalign: store half to 0x2001, then word to 0x3002, then size 11 → three `misalign_o` pulses, `count_o` stays 0, `mem_valid_o` stays 0.
- Full/backpressure: hold `mem_ready_i` = 0 and issue 5 word stores → after 4 accepts `st_ready_o` = 0 and `count_o` = 4. Release `mem_ready_i` → entries drain in order, with addresses and data matching issue order.
- Reset mid-drain: with 3 entries queued, pulse `rst_i` low asynchronously between clock edges → `mem_valid_o` = 0 and `count_o` = 0 immediately. After release the first new store appears one cycle after its accept.
- STORE_MERGE_EN: with `mem_ready_i` = 0, store byte 0x11 to 0x40, then byte 0x22 to 0x41 → `count_o` = 1, `mem_data_o` = 0x00002211, `mem_be_o` = 4'b0011. With the macro undefined → `count_o` = 2.
